// File: rtl/seq_divider_pkg.sv
// Shared types and default widths for the 16-bit sequential restoring divider.
package seq_divider_pkg;

  // Controller states; 2-bit encoding leaves one spare code that recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default dividend/quotient and divisor/remainder widths.
  localparam int DW_DEF = 16;
  localparam int VW_DEF = 8;

  // Iteration counter width for the default dividend width.
  localparam int CW = $clog2(DW_DEF);

endpackage

// File: rtl/seq_divider_16_div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor, keep the difference when it does not go negative.
module div_step #(
  parameter int VW = 8
) (
  input  logic [VW:0]   r,
  input  logic          q_msb,
  input  logic [VW-1:0] d,
  output logic [VW:0]   r_next,
  output logic          q_bit
);

  logic [VW+1:0] t_full_s;
  logic [VW+1:0] d_ext_s;

  // Full-width shifted partial remainder so the compare can never wrap.
  assign t_full_s = {r, q_msb};
  assign d_ext_s  = {2'b00, d};

  // Trial subtraction: subtract and set the quotient bit, or restore.
  always_comb begin
    r_next = t_full_s[VW:0];
    q_bit  = 1'b0;
    if (t_full_s >= d_ext_s) begin
      r_next = t_full_s[VW:0] - d_ext_s[VW:0];
      q_bit  = 1'b1;
    end else begin
      r_next = t_full_s[VW:0];
      q_bit  = 1'b0;
    end
  end

endmodule

// File: rtl/seq_divider_16.sv
// Iterative restoring divider: DW-bit dividend / VW-bit divisor, one quotient
// bit per clock, valid/ready handshake on input and output. Divide by zero
// short-circuits to an all-ones quotient with the low dividend bits as remainder.
module seq_divider_16
  import seq_divider_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CNT_W = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DW - 1);

  state_t           state_r;
  logic [DW-1:0]    q_r;
  logic [VW:0]      r_r;
  logic [VW-1:0]    d_r;
  logic [CNT_W-1:0] cnt_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [DW-1:0]    quotient_r;
  logic [VW-1:0]    remainder_r;
  logic             div_by_zero_r;

  logic [VW:0]      r_next_s;
  logic             q_bit_s;
  logic [DW:0]      q_ext_s;
  logic [DW-1:0]    q_next_s;

  div_step #(.VW(VW)) u_step (
    .r      (r_r),
    .q_msb  (q_r[DW-1]),
    .d      (d_r),
    .r_next (r_next_s),
    .q_bit  (q_bit_s)
  );

  // Quotient register shifted left with the new quotient bit entering at bit 0.
  assign q_ext_s  = {q_r, q_bit_s};
  assign q_next_s = q_ext_s[DW-1:0];

  // Controller and datapath: accept, iterate DW steps, present and hold the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      q_r           <= '0;
      r_r           <= '0;
      d_r           <= '0;
      cnt_r         <= '0;
      in_ready_r    <= 1'b1;
      out_valid_r   <= 1'b0;
      quotient_r    <= '0;
      remainder_r   <= '0;
      div_by_zero_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            q_r        <= dividend;
            r_r        <= '0;
            d_r        <= divisor;
            cnt_r      <= CNT_LAST;
            in_ready_r <= 1'b0;
            if (divisor == '0) begin
              state_r       <= DONE;
              out_valid_r   <= 1'b1;
              quotient_r    <= '1;
              remainder_r   <= dividend[VW-1:0];
              div_by_zero_r <= 1'b1;
            end else begin
              state_r <= BUSY;
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        BUSY: begin
          q_r <= q_next_s;
          r_r <= r_next_s;
          if (cnt_r == '0) begin
            state_r       <= DONE;
            out_valid_r   <= 1'b1;
            quotient_r    <= q_next_s;
            remainder_r   <= r_next_s[VW-1:0];
            div_by_zero_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_seq_divider_16.sv
// Self-checking bench for seq_divider_16: directed cases plus random operands
// compared against plain integer division.
module tb_seq_divider_16;

  localparam int DW = 16;
  localparam int VW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_divider_16 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete operation: accept, wait for the result, optional backpressure, handshake.
  task automatic run_op(input logic [DW-1:0] dvd, input logic [VW-1:0] dvs,
                        input int stall, input bit keep_ready);
    logic [DW-1:0] exp_q;
    logic [VW-1:0] exp_r;
    logic          exp_z;
    int            lat;
    int            n;
    if (dvs == 8'd0) begin
      exp_q = 16'hFFFF;
      exp_r = dvd[VW-1:0];
      exp_z = 1'b1;
      lat   = 0;
    end else begin
      exp_q = dvd / dvs;
      exp_r = 8'(dvd % dvs);
      exp_z = 1'b0;
      lat   = DW;
    end
    out_ready = keep_ready;
    check("in_ready_before_accept", in_ready, 1);
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    tick;                       // accept edge E0
    in_valid = 1'b0;
    dividend = 16'($urandom);   // later operand changes must be ignored
    divisor  = 8'($urandom);
    n = 0;
    while (out_valid !== 1'b1 && n < 64) begin
      tick;
      n++;
    end
    // Edges after E0 until out_valid is seen: DW for a divide, 0 for divide by zero.
    check("latency_edges", n, lat);
    check("quotient", quotient, exp_q);
    check("remainder", remainder, exp_r);
    check("div_by_zero", div_by_zero, exp_z);
    check("in_ready_done", in_ready, 0);
    if (exp_z == 1'b0) begin
      check("invariant", quotient * dvs + remainder, dvd);
    end
    if (!keep_ready) begin
      for (int i = 0; i < stall; i++) begin
        tick;
        check("hold_out_valid", out_valid, 1);
        check("hold_quotient", quotient, exp_q);
        check("hold_remainder", remainder, exp_r);
        check("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
    end
    tick;                       // output handshake edge
    out_ready = keep_ready;
    check("out_valid_after_hs", out_valid, 0);
    check("in_ready_after_hs", in_ready, 1);
  endtask

  initial begin
    logic [DW-1:0] r_dvd;
    logic [VW-1:0] r_dvs;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    tick;
    tick;
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_div_by_zero", div_by_zero, 0);

    run_op(16'd7600, 8'd38, 0, 1'b0);
    run_op(16'd65025, 8'd255, 0, 1'b1);
    run_op(16'd8192, 8'd64, 0, 1'b1);
    out_ready = 1'b0;
    run_op(16'd1, 8'd2, 0, 1'b0);
    run_op(16'hFFFF, 8'd1, 0, 1'b0);
    run_op(16'h1234, 8'd0, 0, 1'b0);
    run_op(16'd50000, 8'd13, 10, 1'b0);

    // Reset during BUSY cycle 5 discards the partial result.
    dividend = 16'd1000;
    divisor  = 8'd7;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_quotient", quotient, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("midrst_no_result", out_valid, 0);
    end
    run_op(16'd1000, 8'd7, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      r_dvd = 16'($urandom);
      r_dvs = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      run_op(r_dvd, r_dvs, $urandom_range(0, 3), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
